// File: rtl/instr_encoder_loader_pkg.sv
// instr_encoder_loader_pkg: LEGv8 op kinds, opcode constants and the instruction encoder
package instr_encoder_loader_pkg;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_LDUR, OP_STUR, OP_CBZ, OP_ILL} op_kind_t;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  function automatic logic [31:0] encode_instr(op_kind_t op, logic [4:0] rd, logic [4:0] rn,
                                               logic [4:0] rm, logic [18:0] imm);
    logic [10:0] opc;
    opc = op == OP_SUB ? OPC_SUB : op == OP_AND ? OPC_AND : op == OP_ORR ? OPC_ORR :
          op == OP_LDUR ? OPC_LDUR : op == OP_STUR ? OPC_STUR : OPC_ADD;
    return op == OP_CBZ ? {OPC_CBZ, imm, rd} :
           (op == OP_LDUR || op == OP_STUR) ? {opc, imm[8:0], 2'b00, rn, rd} :
           {opc, rm, 6'b0, rn, rd};
  endfunction
endpackage

// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if: request side and instruction-memory write side of the loader
interface instr_encoder_loader_if #(parameter int ADDR_W = 6);
  logic              in_valid, in_ready, in_last;
  logic [2:0]        in_op;
  logic [4:0]        in_rd, in_rn, in_rm;
  logic [18:0]       in_imm;
  logic              mem_ready, mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              done, err_ovf, err_ill;
  modport master(output in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last, mem_ready,
                 input in_ready, mem_we, mem_waddr, mem_wdata, done, err_ovf, err_ill);
  modport slave(input in_valid, in_op, in_rd, in_rn, in_rm, in_imm, in_last, mem_ready,
                output in_ready, mem_we, mem_waddr, mem_wdata, done, err_ovf, err_ill);
endinterface

// File: rtl/instr_encoder_loader_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered occupancy count
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wp_d    = wp_q + AW'(do_push);
    rp_d    = rp_q + AW'(do_pop);
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (do_push) mem_q[wp_q] <= din;
  assign full  = cnt_q == CW'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout  = mem_q[rp_q];
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes LEGv8 requests and streams them into instruction memory
module instr_encoder_loader
  import instr_encoder_loader_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int FIFO_DEPTH = 4
) (
  input logic                   clk,
  input logic                   reset,
  instr_encoder_loader_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] MEM_WORDS = {1'b1, {ADDR_W{1'b0}}};
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W:0]   acc_q, acc_d;
  logic drain_q, drain_d, done_q, done_d, ovf_q, ovf_d, ill_q, ill_d;
  logic accept, legal, push, pop, full, empty;
  logic [CW-1:0] count;
  logic [31:0] word, head;
  always_comb begin
    accept  = bus.in_valid && bus.in_ready;
    legal   = op_kind_t'(bus.in_op) != OP_ILL;
    push    = accept && legal;
    pop     = bus.mem_we && bus.mem_ready;
    word    = encode_instr(op_kind_t'(bus.in_op), bus.in_rd, bus.in_rn, bus.in_rm, bus.in_imm);
    // drain completes once the FIFO is (or is about to become) empty; pushes are blocked meanwhile
    done_d  = drain_q && (empty || (pop && count == CW'(1)));
    drain_d = done_d ? 1'b0 : drain_q || (accept && bus.in_last);
    waddr_d = done_d ? '0 : waddr_q + ADDR_W'(pop);
    acc_d   = done_d ? '0 : acc_q + (ADDR_W + 1)'(push);
    ovf_d   = ovf_q || (push && acc_q + 1'b1 == MEM_WORDS);
    ill_d   = ill_q || (accept && !legal);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      waddr_q <= '0;
      acc_q   <= '0;
      drain_q <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      waddr_q <= waddr_d;
      acc_q   <= acc_d;
      drain_q <= drain_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
    end
  end
  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(word),
    .dout(head), .full(full), .empty(empty), .count(count)
  );
  assign bus.in_ready  = !reset && !full && !ovf_q && !drain_q;
  assign bus.mem_we    = !reset && !empty;
  assign bus.mem_wdata = empty ? 32'h0 : head;
  assign bus.mem_waddr = waddr_q;
  assign bus.done      = done_q;
  assign bus.err_ovf   = ovf_q;
  assign bus.err_ill   = ill_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed checks of encoding, stalls, drain/done and error flags
module tb_instr_encoder_loader;
  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rd, rn, rm;
    logic [18:0] imm;
    logic        last;
  } req_t;
  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
    logic [31:0] c;
  } wr_t;
  logic clk = 0, reset = 1;
  int cyc = 0, checks = 0, errors = 0, done_cnt = 0, done_cyc = 0;
  wr_t log_b[$], log_o[$];
  instr_encoder_loader_if #(.ADDR_W(6)) b ();
  instr_encoder_loader_if #(.ADDR_W(2)) o ();
  instr_encoder_loader #(.ADDR_W(6), .FIFO_DEPTH(4)) u_dut (.clk(clk), .reset(reset), .bus(b.slave));
  instr_encoder_loader #(.ADDR_W(2), .FIFO_DEPTH(4)) u_ovf (.clk(clk), .reset(reset), .bus(o.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (b.mem_we && b.mem_ready) log_b.push_back({b.mem_waddr, b.mem_wdata, 32'(cyc)});
    if (o.mem_we && o.mem_ready) log_o.push_back({4'b0, o.mem_waddr, o.mem_wdata, 32'(cyc)});
    if (b.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end
  function automatic req_t mk(logic [2:0] op, logic [4:0] rd, logic [4:0] rn, logic [4:0] rm,
                              logic [18:0] imm, logic last);
    return {op, rd, rn, rm, imm, last};
  endfunction
  task automatic set_req(input req_t r);
    b.in_op = r.op; b.in_rd = r.rd; b.in_rn = r.rn; b.in_rm = r.rm; b.in_imm = r.imm; b.in_last = r.last;
    b.in_valid = 1;
  endtask
  task automatic send(input req_t r);
    set_req(r);
    for (int t = 0; t < 20; t++) begin
      if (b.in_ready) begin
        @(negedge clk);
        b.in_valid = 0;
        return;
      end
      @(negedge clk);
    end
    b.in_valid = 0;
    checks++; errors++;
    $display("FAIL send_timeout: in_ready=%b want 1", b.in_ready);
  endtask
  task automatic do_reset();
    b.in_valid = 0; o.in_valid = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    log_b.delete(); log_o.delete();
  endtask
  task automatic wait_done(input int prev);
    for (int t = 0; t < 20 && done_cnt == prev; t++) @(negedge clk);
    checks++;
    if (done_cnt !== prev + 1) begin errors++; $display("FAIL done_count: got %0d want %0d", done_cnt, prev + 1); end
  endtask
  task automatic test_reset();
    b.mem_ready = 1; o.mem_ready = 1;
    reset = 1;
    @(negedge clk); @(negedge clk);
    checks++;
    if (b.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", b.in_ready); end
    reset = 0;
    @(negedge clk);
    checks++;
    if (b.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready: got %b want 1", b.in_ready); end
    checks++;
    if ({b.mem_we, b.done, b.err_ovf, b.err_ill} !== 4'b0) begin
      errors++; $display("FAIL reset_flags: we/done/ovf/ill got %b want 0000", {b.mem_we, b.done, b.err_ovf, b.err_ill});
    end
    checks++;
    if (b.mem_waddr !== 6'd0 || b.mem_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_bus: waddr=%0d wdata=%h want 0/0", b.mem_waddr, b.mem_wdata);
    end
  endtask
  task automatic test_add();
    do_reset();
    b.mem_ready = 1;
    send(mk(3'd0, 5'd3, 5'd1, 5'd2, 19'd0, 1'b0));
    checks++;
    if (b.mem_we !== 1'b1 || b.mem_waddr !== 6'd0 || b.mem_wdata !== 32'h8B020023) begin
      errors++; $display("FAIL add_word: we=%b waddr=%0d wdata=%h want 1/0/8b020023", b.mem_we, b.mem_waddr, b.mem_wdata);
    end
    @(negedge clk);
    checks++;
    if (b.mem_we !== 1'b0) begin errors++; $display("FAIL add_drained: mem_we=%b want 0", b.mem_we); end
  endtask
  task automatic test_ldur_cbz();
    do_reset();
    b.mem_ready = 1;
    send(mk(3'd4, 5'd9, 5'd10, 5'd0, 19'd8, 1'b0));
    send(mk(3'd6, 5'd5, 5'd0, 5'd0, 19'h7FFFE, 1'b0));
    repeat (4) @(negedge clk);
    checks++;
    if (log_b.size() !== 2) begin errors++; $display("FAIL ldur_cbz_count: got %0d want 2", log_b.size()); end
    else begin
      checks++;
      if (log_b[0].a !== 6'd0 || log_b[0].d !== 32'hF8408149) begin
        errors++; $display("FAIL ldur_word: addr=%0d data=%h want 0/f8408149", log_b[0].a, log_b[0].d);
      end
      checks++;
      if (log_b[1].a !== 6'd1 || log_b[1].d !== 32'hB4FFFFC5) begin
        errors++; $display("FAIL cbz_word: addr=%0d data=%h want 1/b4ffffc5", log_b[1].a, log_b[1].d);
      end
    end
  endtask
  task automatic test_stall();
    req_t reqs[6];
    logic [31:0] want[4];
    int acc = 0;
    logic stable = 1;
    reqs[0] = mk(3'd1, 5'd1, 5'd2, 5'd3, 19'd0, 1'b0);
    reqs[1] = mk(3'd2, 5'd4, 5'd5, 5'd6, 19'd0, 1'b0);
    reqs[2] = mk(3'd3, 5'd7, 5'd8, 5'd9, 19'd0, 1'b0);
    reqs[3] = mk(3'd5, 5'd1, 5'd2, 5'd0, 19'h7FFFF, 1'b0);
    reqs[4] = mk(3'd0, 5'd3, 5'd1, 5'd2, 19'd0, 1'b0);
    reqs[5] = mk(3'd4, 5'd9, 5'd10, 5'd0, 19'd8, 1'b0);
    want = '{32'hCB030041, 32'h8A0600A4, 32'hAA090107, 32'hF81FF041};
    do_reset();
    b.mem_ready = 0;
    for (int c = 0; c < 10; c++) begin
      if (acc < 6) set_req(reqs[acc]);
      if (acc > 0 && b.mem_wdata !== want[0]) stable = 0;
      if (b.in_ready) acc++;
      @(negedge clk);
    end
    b.in_valid = 0;
    checks++;
    if (acc !== 4) begin errors++; $display("FAIL stall_accepts: got %0d want 4", acc); end
    checks++;
    if (b.in_ready !== 1'b0 || b.mem_we !== 1'b1) begin
      errors++; $display("FAIL stall_flags: in_ready=%b mem_we=%b want 0/1", b.in_ready, b.mem_we);
    end
    checks++;
    if (stable !== 1'b1 || b.mem_wdata !== want[0] || log_b.size() !== 0) begin
      errors++; $display("FAIL stall_hold: stable=%b wdata=%h writes=%0d want 1/%h/0", stable, b.mem_wdata, log_b.size(), want[0]);
    end
    b.mem_ready = 1;
    repeat (6) @(negedge clk);
    checks++;
    if (log_b.size() !== 4) begin errors++; $display("FAIL stall_release_count: got %0d want 4", log_b.size()); end
    else for (int k = 0; k < 4; k++) begin
      checks++;
      if (log_b[k].a !== 6'(k) || log_b[k].d !== want[k]) begin
        errors++; $display("FAIL stall_word%0d: addr=%0d data=%h want %0d/%h", k, log_b[k].a, log_b[k].d, k, want[k]);
      end
    end
  endtask
  task automatic test_program();
    int dc, w2;
    do_reset();
    b.mem_ready = 1;
    dc = done_cnt;
    send(mk(3'd0, 5'd3, 5'd1, 5'd2, 19'd0, 1'b0));
    send(mk(3'd1, 5'd1, 5'd2, 5'd3, 19'd0, 1'b0));
    send(mk(3'd2, 5'd4, 5'd5, 5'd6, 19'd0, 1'b1));
    checks++;
    if (b.in_ready !== 1'b0) begin errors++; $display("FAIL last_blocks: in_ready=%b want 0", b.in_ready); end
    wait_done(dc);
    w2 = -10;
    foreach (log_b[k]) if (log_b[k].a == 6'd2) w2 = int'(log_b[k].c);
    checks++;
    if (log_b.size() !== 3 || done_cyc !== w2 + 1) begin
      errors++; $display("FAIL done_timing: writes=%0d done_cyc=%0d want 3/%0d", log_b.size(), done_cyc, w2 + 1);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (b.in_ready !== 1'b1 || done_cnt !== dc + 1) begin
      errors++; $display("FAIL after_done: in_ready=%b dones=%0d want 1/%0d", b.in_ready, done_cnt, dc + 1);
    end
    dc = done_cnt;
    send(mk(3'd3, 5'd7, 5'd8, 5'd9, 19'd0, 1'b1));
    wait_done(dc);
    checks++;
    if (log_b[$].a !== 6'd0 || log_b[$].d !== 32'hAA090107) begin
      errors++; $display("FAIL next_program: addr=%0d data=%h want 0/aa090107", log_b[$].a, log_b[$].d);
    end
  endtask
  task automatic test_illegal();
    int dc;
    do_reset();
    b.mem_ready = 1;
    send(mk(3'd7, 5'd1, 5'd1, 5'd1, 19'd0, 1'b0));
    checks++;
    if (b.err_ill !== 1'b1 || b.mem_we !== 1'b0) begin
      errors++; $display("FAIL illegal_flag: err_ill=%b mem_we=%b want 1/0", b.err_ill, b.mem_we);
    end
    send(mk(3'd0, 5'd3, 5'd1, 5'd2, 19'd0, 1'b0));
    repeat (3) @(negedge clk);
    checks++;
    if (log_b.size() !== 1 || log_b[0].a !== 6'd0 || log_b[0].d !== 32'h8B020023) begin
      errors++; $display("FAIL illegal_next: writes=%0d addr=%0d data=%h want 1/0/8b020023", log_b.size(), log_b[0].a, log_b[0].d);
    end
    dc = done_cnt;
    send(mk(3'd7, 5'd0, 5'd0, 5'd0, 19'd0, 1'b1));
    wait_done(dc);
    checks++;
    if (b.err_ill !== 1'b1 || log_b.size() !== 1) begin
      errors++; $display("FAIL illegal_last: err_ill=%b writes=%0d want 1/1", b.err_ill, log_b.size());
    end
  endtask
  task automatic test_overflow();
    int acc = 0;
    do_reset();
    o.mem_ready = 1;
    o.in_op = 3'd0; o.in_rn = 5'd1; o.in_rm = 5'd2; o.in_imm = '0; o.in_last = 0;
    for (int c = 0; c < 10; c++) begin
      o.in_valid = acc < 5;
      o.in_rd = 5'(acc);
      if (o.in_valid && o.in_ready) acc++;
      @(negedge clk);
    end
    o.in_valid = 0;
    checks++;
    if (acc !== 4 || o.err_ovf !== 1'b1 || o.in_ready !== 1'b0) begin
      errors++; $display("FAIL overflow: accepts=%0d err_ovf=%b in_ready=%b want 4/1/0", acc, o.err_ovf, o.in_ready);
    end
    checks++;
    if (log_o.size() !== 4 || o.mem_we !== 1'b0) begin
      errors++; $display("FAIL overflow_writes: writes=%0d mem_we=%b want 4/0", log_o.size(), o.mem_we);
    end
    else for (int k = 0; k < 4; k++) begin
      checks++;
      if (log_o[k].a !== 6'(k) || log_o[k].d !== 32'h8B020020 + 32'(k)) begin
        errors++; $display("FAIL overflow_word%0d: addr=%0d data=%h want %0d/%h", k, log_o[k].a, log_o[k].d, k, 32'h8B020020 + 32'(k));
      end
    end
  endtask
  task automatic test_reset_mid_stall();
    do_reset();
    o.mem_ready = 0;
    o.in_valid = 1;
    repeat (2) @(negedge clk);
    o.in_valid = 0;
    checks++;
    if (o.mem_we !== 1'b1) begin errors++; $display("FAIL stall_before_reset: mem_we=%b want 1", o.mem_we); end
    reset = 1;
    @(negedge clk);
    reset = 0;
    checks++;
    if (o.mem_we !== 1'b0 || o.err_ovf !== 1'b0) begin
      errors++; $display("FAIL reset_mid_stall: mem_we=%b err_ovf=%b want 0/0", o.mem_we, o.err_ovf);
    end
    o.mem_ready = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (log_o.size() !== 0) begin errors++; $display("FAIL reset_discard: writes=%0d want 0", log_o.size()); end
  endtask
  initial begin
    b.in_valid = 0; b.in_op = 0; b.in_rd = 0; b.in_rn = 0; b.in_rm = 0; b.in_imm = 0; b.in_last = 0; b.mem_ready = 0;
    o.in_valid = 0; o.in_op = 0; o.in_rd = 0; o.in_rn = 0; o.in_rm = 0; o.in_imm = 0; o.in_last = 0; o.mem_ready = 0;
    @(negedge clk);
    test_reset();
    test_add();
    test_ldur_cbz();
    test_stall();
    test_program();
    test_illegal();
    test_overflow();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
